// File: rtl/product_bcd_converter.sv
// Signed product to sign-magnitude BCD converter (sequential double-dabble, one bit per clock).
// Optional build macro BCD_LEADING_BLANK_EN replaces leading zero digits with 4'hF.
module product_bcd_converter #(
    parameter int W      = 64,
    parameter int DIGITS = 20
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [W-1:0]          in_prod,
    input  logic                  in_valid,
    output logic                  busy,
    output logic                  out_sign,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_valid
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state;
    logic [W-1:0]    mag;
    logic [BW-1:0]   acc;
    logic [CW-1:0]   count;
    logic            sign;

    logic [W-1:0]    abs_prod;
    logic [BW-1:0]   acc_adj;
    logic [BW-1:0]   acc_next;
    logic [BW-1:0]   result;
    logic            last_shift;

    // Two's-complement negate as unsigned W bits, so -2^(W-1) maps to 2^(W-1).
    assign abs_prod   = in_prod[W-1] ? (~in_prod + W'(1)) : in_prod;
    assign last_shift = (count == CW'(W - 1));

    // NOTE: every variable gets a default at the top of an always_comb so no latch is inferred.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_next = {acc_adj[BW-2:0], mag[W-1]};
    end

`ifdef BCD_LEADING_BLANK_EN
    logic seen_nonzero;

    // Blank every digit above the most significant non-zero one; digit 0 always shows.
    always_comb begin
        result       = acc_next;
        seen_nonzero = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (acc_next[4*i +: 4] != 4'd0)
                seen_nonzero = 1'b1;
            if (!seen_nonzero)
                result[4*i +: 4] = 4'hF;
        end
    end
`else
    assign result = acc_next;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_bcd   <= '0;
            mag       <= '0;
            acc       <= '0;
            count     <= '0;
            sign      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= in_prod[W-1];
                        mag   <= abs_prod;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_next;
                    mag   <= {mag[W-2:0], 1'b0};
                    count <= count + CW'(1);
                    if (last_shift) begin
                        out_bcd   <= result;
                        // A zero magnitude never reports as negative.
                        out_sign  <= sign && (acc_next != '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench for product_bcd_converter: directed corner cases plus random operands
// checked against a decimal-arithmetic reference model.
module tb_product_bcd_converter;

    localparam int W      = 64;
    localparam int DIGITS = 20;
    localparam int BW     = 4 * DIGITS;

    logic          CLK = 1'b0;
    logic          reset;
    logic [W-1:0]  in_prod;
    logic          in_valid;
    logic          busy;
    logic          out_sign;
    logic [BW-1:0] out_bcd;
    logic          out_valid;

    typedef struct {
        logic          sign;
        logic [BW-1:0] bcd;
    } result_t;

    result_t       sb[$];
    int            checks   = 0;
    int            failures = 0;
    bit            mon_en   = 1'b0;
    logic          hold_sign = 1'b0;
    logic [BW-1:0] hold_bcd  = '0;

    product_bcd_converter #(.W(W), .DIGITS(DIGITS)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .in_prod  (in_prod),
        .in_valid (in_valid),
        .busy     (busy),
        .out_sign (out_sign),
        .out_bcd  (out_bcd),
        .out_valid(out_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference: repeated division by ten on the absolute value.
    function automatic result_t model(input logic [W-1:0] v);
        result_t          r;
        logic [W-1:0]     m;
        int               msd;
        m      = v[W-1] ? (64'd0 - v) : v;
        r.sign = v[W-1];
        r.bcd  = '0;
        msd    = 0;
        for (int i = 0; i < DIGITS; i++) begin
            r.bcd[4*i +: 4] = 4'(m % 10);
            if (m % 10 != 0) msd = i;
            m = m / 10;
        end
`ifdef BCD_LEADING_BLANK_EN
        for (int i = 1; i < DIGITS; i++)
            if (i > msd) r.bcd[4*i +: 4] = 4'hF;
`endif
        return r;
    endfunction

    // Monitor: pops the scoreboard on every out_valid, otherwise checks outputs hold.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: got bcd %h with empty scoreboard", out_bcd);
                end else begin
                    result_t e;
                    e = sb.pop_front();
                    check("result_bcd", out_bcd, e.bcd);
                    check("result_sign", BW'(out_sign), BW'(e.sign));
                    hold_bcd  = e.bcd;
                    hold_sign = e.sign;
                end
            end else begin
                check("hold_bcd", out_bcd, hold_bcd);
                check("hold_sign", BW'(out_sign), BW'(hold_sign));
            end
        end
    end

    // Called at #1 after a posedge; operand is accepted on the next posedge.
    task automatic start(input logic [W-1:0] v);
        in_prod  = v;
        in_valid = 1'b1;
        sb.push_back(model(v));
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check("busy_after_accept", BW'(busy), BW'(1));
    endtask

    // Waits for out_valid, counting clocks since acceptance; expects exactly W.
    task automatic wait_done();
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL timeout: no out_valid after %0d cycles", n);
        end else begin
            check("latency", BW'(n), BW'(W));
            check("busy_on_valid", BW'(busy), BW'(0));
        end
    endtask

    task automatic convert(input logic [W-1:0] v);
        start(v);
        wait_done();
    endtask

    initial begin
        reset    = 1'b0;
        in_prod  = '0;
        in_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", BW'(busy), BW'(0));
        check("reset_valid", BW'(out_valid), BW'(0));
        check("reset_sign", BW'(out_sign), BW'(0));
        check("reset_bcd", out_bcd, '0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Directed values
        convert(64'd2700);
`ifndef BCD_LEADING_BLANK_EN
        check("bcd_2700_const", out_bcd, 80'h2700);
`endif
        convert(-64'sd2700);
        check("sign_neg2700", BW'(out_sign), BW'(1));
        convert(64'd0);
        check("sign_zero", BW'(out_sign), BW'(0));
        convert(64'h4000_0000_0000_0000);
`ifndef BCD_LEADING_BLANK_EN
        check("bcd_2p62_const", out_bcd, 80'h4611686018427387904);
`endif
        convert(64'h8000_0000_0000_0000);
        check("sign_min", BW'(out_sign), BW'(1));
`ifndef BCD_LEADING_BLANK_EN
        check("bcd_min_const", out_bcd, 80'h9223372036854775808);
`endif

        // in_valid while busy is dropped; in_valid on the out_valid cycle is accepted
        start(64'd2700);
        for (int n = 1; n < W; n++) begin
            if (n == 9 || n == 39) begin
                in_prod  = 64'd999;
                in_valid = 1'b1;
            end
            @(posedge CLK); #1;
            in_valid = 1'b0;
            if (n == 10 || n == 40)
                check("busy_ignored_pulse", BW'(busy), BW'(1));
        end
        @(posedge CLK); #1;
        check("valid_after_ignored", BW'(out_valid), BW'(1));
        convert(64'd999);

        // Reset mid-conversion aborts without a result
        in_prod  = -64'sd30;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge CLK);
        #1;
        reset = 1'b0;
        @(posedge CLK); #1;
        hold_bcd  = '0;
        hold_sign = 1'b0;
        check("abort_busy", BW'(busy), BW'(0));
        check("abort_bcd", out_bcd, '0);
        check("abort_sign", BW'(out_sign), BW'(0));
        reset = 1'b1;
        repeat (W + 5) @(posedge CLK);
        #1;
        convert(64'd90);

        // Random operands, back-to-back on the out_valid cycle
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] v;
            case (i % 3)
                0: v = {$urandom(), $urandom()};
                1: v = W'($signed($urandom_range(0, 20000)) - 10000);
                default: v = {{32{$urandom_range(0, 1) == 1}}, $urandom()};
            endcase
            convert(v);
        end

        repeat (3) @(posedge CLK);
        #1;
        check("scoreboard_empty", BW'(sb.size()), BW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
